// File: rtl/store_buffer_if.sv
// Bundle of store-buffer pipeline signals (store/load side) and data-memory port signals.
// slave = the store buffer's view, master = the pipeline/memory environment's view.
interface store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_stall;
    logic          empty;
    logic          DMWE;
    logic [AW-1:0] DMA;
    logic [DW-1:0] DMWD;
    logic [DW-1:0] DMRD;

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, DMRD,
        output st_ready, ld_data, ld_stall, empty, DMWE, DMA, DMWD
    );

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, DMRD,
        input  st_ready, ld_data, ld_stall, empty, DMWE, DMA, DMWD
    );
endinterface

// File: rtl/store_buffer.sv
// Memory-stage store buffer: FIFO of retired stores drained to DM in idle port cycles.
// Define STORE_BUF_FWD_EN to forward buffered data to loads; otherwise matching loads stall and force a drain.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];

    logic          full;
    logic          enq;
    logic          drain;
    logic          match;
    logic [PW-1:0] idx;
`ifdef STORE_BUF_FWD_EN
    logic [DW-1:0] fwd_data;
`endif

    assign full        = (count_q == CW'(DEPTH));
    assign sb.st_ready = !full;
    assign sb.empty    = (count_q == '0);
    assign enq         = sb.st_valid && !full;

    // Walk entries oldest to youngest so the last hit is the youngest store.
    always_comb begin
        match = 1'b0;
        idx   = '0;
`ifdef STORE_BUF_FWD_EN
        fwd_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && (addr_q[idx] == sb.ld_addr)) begin
                match = 1'b1;
`ifdef STORE_BUF_FWD_EN
                fwd_data = data_q[idx];
`endif
            end
        end
    end

`ifdef STORE_BUF_FWD_EN
    assign drain      = (count_q != '0) && (!sb.ld_valid || full);
    assign sb.ld_data = match ? fwd_data : sb.DMRD;
`else
    // A load hitting a buffered address must wait until that store reaches DM.
    assign drain      = (count_q != '0) && (!sb.ld_valid || full || match);
    assign sb.ld_data = sb.DMRD;
`endif

    assign sb.ld_stall = sb.ld_valid && drain;
    assign sb.DMWE     = drain;
    assign sb.DMA      = drain ? addr_q[head_q] : sb.ld_addr;
    assign sb.DMWD     = drain ? data_q[head_q] : '0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        if (drain) begin
            head_d          = head_q + PW'(1);
            valid_d[head_q] = 1'b0;
        end
        if (enq) begin
            tail_d          = tail_q + PW'(1);
            valid_d[tail_q] = 1'b1;
        end
        count_d = count_q + CW'(enq) - CW'(drain);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload needs no reset: it is only observed through set valid bits / nonzero count.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= sb.st_addr;
            data_q[tail_q] <= sb.st_data;
        end
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Memory-stage store buffer sitting directly upstream of the data memory (DM); it owns DM's single port (DMWE/DMA/DMWD) and sees DM's read data (DMRD).
- Retires stores from the MEM pipeline stage into a small FIFO, drains them to DM in idle cycles, and forwards buffered data to younger loads.
- Removes load/store port conflicts without stalling the pipeline on every store.

Parameters:
DEPTH, 4, number of buffered stores (power of 2, >=2)
AW, 32, address width (word address, same indexing as DM)
DW, 32, data width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
st_valid  in  1  MEM stage presents a store this cycle
st_addr  in  AW  store word address
st_data  in  DW  store data
st_ready  out  1  buffer can accept a store (not full)
ld_valid  in  1  MEM stage presents a load this cycle
ld_addr  in  AW  load word address
ld_data  out  DW  load result (forwarded or from DM)
ld_stall  out  1  load not served this cycle; pipeline must hold and retry
empty  out  1  no buffered stores (used for fences/halt)
DMWE  out  1  DM write enable
DMA  out  AW  DM address
DMWD  out  DW  DM write data
DMRD  in  DW  DM read data (combinational; valid only when DMWE=0)

Behaviour:
- Reset (async, rst_n=0): head=tail=count=0, all entry valid bits cleared. Resulting outputs: DMWE=0, DMA=ld_addr, DMWD=0, st_ready=1, empty=1, ld_stall=0. Reset mid-drain discards all buffered stores.
- Storage: circular FIFO of {addr, data}; head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
- Enqueue: at posedge, if st_valid && st_ready, write entry at tail and advance tail. st_ready = (count != DEPTH), registered-state based; no same-cycle pass-through when full. st_valid while full is ignored; upstream holds.
- Port arbitration, evaluated each cycle:
  - drain = (count!=0) && (!ld_valid || count==DEPTH).
  - Drain: DMWE=1, DMA=head.addr, DMWD=head.data; at posedge pop head.
  - Otherwise DMWE=0, DMA=ld_addr, DMWD=0.
- Loads:
  - ld_stall = ld_valid && drain (only possible when full).
  - Forwarding: search all valid entries, including the head being drained; youngest matching addr wins.
  - ld_data = hit ? entry.data : DMRD.
  - ld_data is combinational, valid the same cycle when ld_stall=0.
- Simultaneous store and load: store enqueues at posedge. The load does not see that same-cycle store (MEM ordering guarantees the load is older).
- Simultaneous enqueue and pop: count unchanged, both pointers advance.
- Same-address stores: all buffered and drained in order; DM ends with the youngest.
- No latency added to loads; a store reaches DM at least 1 cycle after enqueue.

Optional Feature:
STORE_BUF_FWD_EN
- Defined: forwarding as above.
- Undefined: no forwarding muxes. A load whose addr matches any valid entry asserts ld_stall=1 and forces drain that cycle regardless of ld_valid. Once no entry matches, the load is served from DMRD.
- Non-matching loads behave identically in both builds.

Test Plan:
- Reset then idle: rst_n low mid-run with count=3 -> empty=1, DMWE=0, st_ready=1 immediately (async); no further DM writes.
- Store addr 5 data 0x11, next cycle no load -> DMWE=1, DMA=5, DMWD=0x11 for one cycle, then empty=1.
- Stores addr 2=0xA then addr 2=0xB; load addr 2 every cycle -> ld_data=0xB with ld_stall=0 (FWD_EN). Without the macro: ld_stall=1 until both entries drain, then ld_data=DMRD=0xB.
- Fill with 4 stores (addrs 0..3) while loads to addr 9 assert every cycle -> st_ready=0. Next cycle drain wins: ld_stall=1, DMA=0. Then st_ready=1 and the load is served from DMRD.
- Store and pop in the same cycle at count=2, with pointer wrap from DEPTH-1 to 0 -> count stays 2, drain order preserved, DM writes in enqueue order.
- Load addr 7 with empty buffer -> DMWE=0, DMA=7, ld_data=DMRD, ld_stall=0.
